// File: rtl/alu.sv
// Registered WIDTH-bit ALU: add, subtract, AND, NOT-B with a registered zero flag.
// Define ALU_FLAGS_EN to add registered negative (N) and signed-overflow (V) outputs.
module alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  input  logic [1:0]       ALUop,
  output logic [WIDTH-1:0] out,
  output logic             Z,
  output logic             out_valid
`ifdef ALU_FLAGS_EN
  ,
  output logic             N,
  output logic             V
`endif
);

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_NOTB = 2'b11;

  // True when every bit of the value is clear.
  function automatic logic is_zero(input logic [WIDTH-1:0] value);
    is_zero = (value == {WIDTH{1'b0}});
  endfunction

  logic             is_sub_s;
  logic [WIDTH-1:0] b_operand_s;
  logic [WIDTH-1:0] carry_in_s;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] result_s;
  logic             zero_s;

  logic [WIDTH-1:0] out_r;
  logic             z_r;
  logic             out_valid_r;

  // Shared adder: subtraction is A + ~B + 1, carry out falls off the top.
  always_comb begin
    is_sub_s    = (ALUop == OP_SUB);
    b_operand_s = is_sub_s ? ~Bin : Bin;
    carry_in_s  = {{(WIDTH-1){1'b0}}, is_sub_s};
    sum_s       = Ain + b_operand_s + carry_in_s;
  end

  // Result select; NOT-B never looks at Ain so an unknown Ain cannot leak.
  always_comb begin
    result_s = {WIDTH{1'b0}};
    case (ALUop)
      OP_ADD:  result_s = sum_s;
      OP_SUB:  result_s = sum_s;
      OP_AND:  result_s = Ain & Bin;
      OP_NOTB: result_s = ~Bin;
      default: result_s = {WIDTH{1'b0}};
    endcase
    zero_s = is_zero(result_s);
  end

  // Result and zero flag load only on accepted operations; otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r       <= {WIDTH{1'b0}};
      z_r         <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (in_valid) begin
      out_r       <= result_s;
      z_r         <= zero_s;
      out_valid_r <= 1'b1;
    end else begin
      out_valid_r <= 1'b0;
    end
  end

  assign out       = out_r;
  assign Z         = z_r;
  assign out_valid = out_valid_r;

`ifdef ALU_FLAGS_EN
  logic n_s;
  logic v_s;
  logic n_r;
  logic v_r;

  // With B already inverted for subtract, one rule covers both: operands
  // of equal sign producing a result of the other sign.
  always_comb begin
    n_s = result_s[WIDTH-1];
    v_s = 1'b0;
    case (ALUop)
      OP_ADD, OP_SUB: v_s = (Ain[WIDTH-1] == b_operand_s[WIDTH-1]) &&
                            (sum_s[WIDTH-1] != Ain[WIDTH-1]);
      default:        v_s = 1'b0;
    endcase
  end

  // Flags follow the same load/hold/reset rules as the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_r <= 1'b0;
      v_r <= 1'b0;
    end else if (in_valid) begin
      n_r <= n_s;
      v_r <= v_s;
    end else begin
      n_r <= n_r;
      v_r <= v_r;
    end
  end

  assign N = n_r;
  assign V = v_r;
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: vector table plus scoreboard queue of expected results.
module tb_alu;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] Ain;
  logic [W-1:0] Bin;
  logic [1:0]   ALUop;
  logic [W-1:0] out;
  logic         Z;
  logic         out_valid;
`ifdef ALU_FLAGS_EN
  logic         N;
  logic         V;
`endif

  alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .Ain       (Ain),
    .Bin       (Bin),
    .ALUop     (ALUop),
    .out       (out),
    .Z         (Z),
    .out_valid (out_valid)
`ifdef ALU_FLAGS_EN
    ,
    .N         (N),
    .V         (V)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic [W-1:0] exp_out;
    logic         exp_z;
    logic         exp_n;
    logic         exp_v;
  } vec_t;

  typedef struct {
    logic [W-1:0] out;
    logic         z;
    logic         n;
    logic         v;
  } res_t;

  vec_t vecs[9];
  res_t exp_q[$];
  int   tests;
  int   fails;
  logic pend_valid;
  res_t last;

  task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Independent reference using ordinary signed arithmetic.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    res_t r;
    logic signed [W:0] wide;
    r.v = 1'b0;
    case (op)
      2'b00: begin
        r.out = a + b;
        wide  = $signed({a[W-1], a}) + $signed({b[W-1], b});
        r.v   = (wide > $signed(17'sd32767)) || (wide < -$signed(17'sd32768));
      end
      2'b01: begin
        r.out = a - b;
        wide  = $signed({a[W-1], a}) - $signed({b[W-1], b});
        r.v   = (wide > $signed(17'sd32767)) || (wide < -$signed(17'sd32768));
      end
      2'b10: r.out = a & b;
      default: r.out = ~b;
    endcase
    r.z = (r.out == 16'h0000);
    r.n = r.out[W-1];
    return r;
  endfunction

  task automatic check_outputs(input string tag);
    res_t e;
    cmp({tag, "_valid"}, {15'd0, out_valid}, {15'd0, pend_valid});
    if (pend_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL %s_queue: got empty scoreboard, expected an entry", tag);
        return;
      end
      e = exp_q.pop_front();
      last = e;
    end else begin
      e = last;
    end
    cmp({tag, "_out"}, out, e.out);
    cmp({tag, "_z"}, {15'd0, Z}, {15'd0, e.z});
`ifdef ALU_FLAGS_EN
    cmp({tag, "_n"}, {15'd0, N}, {15'd0, e.n});
    cmp({tag, "_v"}, {15'd0, V}, {15'd0, e.v});
`endif
  endtask

  task automatic apply(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] op, input res_t e);
    in_valid = v;
    Ain      = a;
    Bin      = b;
    ALUop    = op;
    if (v) exp_q.push_back(e);
    pend_valid = v;
  endtask

  task automatic step(input string tag, input logic v, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [1:0] op, input res_t e);
    @(negedge clk);
    check_outputs(tag);
    apply(v, a, b, op, e);
  endtask

  res_t zero_res;
  res_t r;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests = 0;
    fails = 0;
    zero_res = '{out: 16'h0000, z: 1'b0, n: 1'b0, v: 1'b0};
    last = zero_res;
    pend_valid = 1'b0;

    vecs[0] = '{a: 16'd25,   b: 16'd42,   op: 2'b00, exp_out: 16'd67,   exp_z: 1'b0, exp_n: 1'b0, exp_v: 1'b0};
    vecs[1] = '{a: 16'd42,   b: 16'd25,   op: 2'b01, exp_out: 16'd17,   exp_z: 1'b0, exp_n: 1'b0, exp_v: 1'b0};
    vecs[2] = '{a: 16'd25,   b: 16'd42,   op: 2'b01, exp_out: 16'hFFEF, exp_z: 1'b0, exp_n: 1'b1, exp_v: 1'b0};
    vecs[3] = '{a: 16'd25,   b: 16'd42,   op: 2'b10, exp_out: 16'd8,    exp_z: 1'b0, exp_n: 1'b0, exp_v: 1'b0};
    vecs[4] = '{a: 16'h1234, b: 16'h00B6, op: 2'b11, exp_out: 16'hFF49, exp_z: 1'b0, exp_n: 1'b1, exp_v: 1'b0};
    vecs[5] = '{a: 16'd25,   b: 16'd25,   op: 2'b01, exp_out: 16'h0000, exp_z: 1'b1, exp_n: 1'b0, exp_v: 1'b0};
    vecs[6] = '{a: 16'hFFFF, b: 16'h0001, op: 2'b00, exp_out: 16'h0000, exp_z: 1'b1, exp_n: 1'b0, exp_v: 1'b0};
    vecs[7] = '{a: 16'h7FFF, b: 16'h0001, op: 2'b00, exp_out: 16'h8000, exp_z: 1'b0, exp_n: 1'b1, exp_v: 1'b1};
    vecs[8] = '{a: 16'hFFFA, b: 16'hFFE8, op: 2'b00, exp_out: 16'hFFE2, exp_z: 1'b0, exp_n: 1'b1, exp_v: 1'b0};

    rst_n    = 1'b0;
    in_valid = 1'b1;
    Ain      = 16'd7;
    Bin      = 16'd9;
    ALUop    = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs("reset_hold");
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // Table vectors back-to-back, one per cycle.
    for (int i = 0; i < 9; i++) begin
      r = '{out: vecs[i].exp_out, z: vecs[i].exp_z, n: vecs[i].exp_n, v: vecs[i].exp_v};
      step($sformatf("vec%0d", i), 1'b1, vecs[i].a, vecs[i].b, vecs[i].op, r);
    end

    // Idle with changing inputs: last result (FFE2) must hold.
    for (int i = 0; i < 3; i++)
      step($sformatf("hold%0d", i), 1'b0, 16'h1111 * (i + 1), 16'h2222 + i[15:0], i[1:0], zero_res);
    step("hold3", 1'b0, 16'h0000, 16'h0000, 2'b00, zero_res);

    // Four consecutive ops 00..11.
    for (int i = 0; i < 4; i++)
      step($sformatf("b2b%0d", i), 1'b1, 16'h4321, 16'h1357, i[1:0], model(16'h4321, 16'h1357, i[1:0]));

    // Random mix of valid and idle cycles.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic [1:0]   rop;
      logic         rv;
      ra  = W'($urandom);
      rb  = W'($urandom);
      rop = 2'($urandom);
      rv  = ($urandom_range(0, 3) != 0);
      step($sformatf("rnd%0d", i), rv, ra, rb, rop, model(ra, rb, rop));
    end
    @(negedge clk);
    check_outputs("rnd_last");

    // Load a nonzero result, then reset asynchronously mid-cycle.
    apply(1'b1, 16'd100, 16'd3, 2'b00, model(16'd100, 16'd3, 2'b00));
    @(negedge clk);
    check_outputs("pre_reset");
    in_valid = 1'b1;
    Ain      = 16'd5;
    Bin      = 16'd6;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    pend_valid = 1'b0;
    last = zero_res;
    cmp("async_rst_out", out, 16'h0000);
    cmp("async_rst_z", {15'd0, Z}, 16'h0000);
    cmp("async_rst_valid", {15'd0, out_valid}, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    check_outputs("in_reset");

    // Release with in_valid high: first edge gives a normal result.
    rst_n = 1'b1;
    apply(1'b1, 16'd25, 16'd42, 2'b01, model(16'd25, 16'd42, 2'b01));
    step("post_reset", 1'b0, 16'h0000, 16'h0000, 2'b00, zero_res);
    step("post_reset_idle", 1'b0, 16'h0000, 16'h0000, 2'b00, zero_res);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
